// File: rtl/lif_spike_encoder.sv
// rtl/lif_spike_encoder.sv - four-channel leaky integrate-and-fire spike encoder
module lif_spike_encoder #(
  parameter int MEM_W  = 12,
  parameter int MAG_W  = 8,
  parameter int REFR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [MEM_W-1:0]  threshold,
  input  logic [7:0]        leak_amt,
  input  logic [7:0]        leak_period,
  input  logic [REFR_W-1:0] refractory,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        s_ch,
  input  logic [MAG_W-1:0]  s_mag,
  output logic [3:0]        spike_o,
  input  logic [1:0]        mem_sel,
  output logic [MEM_W-1:0]  mem_out,
  output logic [15:0]       spike_count,
  output logic [7:0]        drop_count
);

  logic [MEM_W-1:0]  mem_q  [4];
  logic [MEM_W-1:0]  mem_d  [4];
  logic [REFR_W-1:0] refr_q [4];
  logic [3:0]        in_refr;
  logic [3:0]        fire;
  logic [3:0]        drop_hit;
  logic [3:0]        spike_q;
  logic [7:0]        leak_cnt;
  logic              tick;
  logic              accept;
  logic [2:0]        fire_cnt;
  logic [MEM_W-1:0]  leak_ext;
  logic [REFR_W-1:0] refr_load;

  assign s_ready   = enable;
  assign accept    = s_valid & enable;
  assign spike_o   = spike_q;
  assign mem_out   = mem_q[mem_sel];
  assign leak_ext  = {{(MEM_W-8){1'b0}}, leak_amt};
  assign refr_load = (refractory == '0) ? REFR_W'(1) : refractory;
  assign tick      = enable && (leak_period != 8'd0) && (leak_cnt == leak_period - 8'd1);
  assign fire_cnt  = {2'b00, fire[0]} + {2'b00, fire[1]} + {2'b00, fire[2]} + {2'b00, fire[3]};

  for (genvar c = 0; c < 4; c++) begin : g_ch
    logic             hit;
    logic [MEM_W:0]   leaked;
    logic [MEM_W:0]   summed;
    logic [MEM_W-1:0] m;

    assign hit = accept && (s_ch == 2'(c));

    // One spare bit on the sum so the add saturates instead of wrapping.
    always_comb begin
      leaked = {1'b0, mem_q[c]};
      if (tick) begin
        leaked = (mem_q[c] >= leak_ext) ? {1'b0, mem_q[c] - leak_ext} : '0;
      end
      summed = leaked;
      if (hit) begin
        summed = leaked + {{(MEM_W+1-MAG_W){1'b0}}, s_mag};
      end
      m = summed[MEM_W] ? '1 : summed[MEM_W-1:0];
    end

    assign in_refr[c]  = (refr_q[c] != '0);
    assign fire[c]     = !in_refr[c] && (threshold != '0) && (m >= threshold);
    assign drop_hit[c] = in_refr[c] && hit;
    assign mem_d[c]    = fire[c] ? '0 : m;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i]  <= '0;
        refr_q[i] <= '0;
      end
      leak_cnt    <= 8'd0;
      spike_q     <= 4'd0;
      spike_count <= 16'd0;
      drop_count  <= 8'd0;
    end else if (!enable) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i]  <= '0;
        refr_q[i] <= '0;
      end
      leak_cnt <= 8'd0;
      spike_q  <= 4'd0;
    end else begin
      // Refractory channels hold their membrane and ignore the fire check.
      for (int i = 0; i < 4; i++) begin
        if (in_refr[i]) begin
          refr_q[i] <= refr_q[i] - REFR_W'(1);
        end else begin
          mem_q[i] <= mem_d[i];
          if (fire[i]) begin
            refr_q[i] <= refr_load;
          end
        end
      end
      spike_q     <= fire;
      spike_count <= spike_count + {13'd0, fire_cnt};
      if ((|drop_hit) && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
      // A period shrunk below the running count wraps through 0xFF.
      if (leak_period != 8'd0) begin
        leak_cnt <= tick ? 8'd0 : leak_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lif_spike_encoder.sv
// tb/tb_lif_spike_encoder.sv - scoreboard bench for lif_spike_encoder
module tb_lif_spike_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] threshold;
  logic [7:0]  leak_amt;
  logic [7:0]  leak_period;
  logic [3:0]  refractory;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_ch;
  logic [7:0]  s_mag;
  logic [3:0]  spike_o;
  logic [1:0]  mem_sel;
  logic [11:0] mem_out;
  logic [15:0] spike_count;
  logic [7:0]  drop_count;

  lif_spike_encoder dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .threshold(threshold),
    .leak_amt(leak_amt), .leak_period(leak_period), .refractory(refractory),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_mag(s_mag),
    .spike_o(spike_o), .mem_sel(mem_sel), .mem_out(mem_out),
    .spike_count(spike_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  spike;
    logic [11:0] mem;
    logic [15:0] sc;
    logic [7:0]  dc;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  int   m_mem[4];
  int   m_refr[4];
  int   m_lc, m_sc, m_dc;
  logic [3:0] m_spike;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: apply one clock edge of the spec's rules to the model, queue what the DUT should then show.
  task automatic cycle();
    exp_t e;
    bit   tick;
    int   m;
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin m_mem[c] = 0; m_refr[c] = 0; end
      m_lc = 0; m_sc = 0; m_dc = 0; m_spike = 0;
    end else if (!enable) begin
      for (int c = 0; c < 4; c++) begin m_mem[c] = 0; m_refr[c] = 0; end
      m_lc = 0; m_spike = 0;
    end else begin
      tick = 0;
      if (leak_period != 0) begin
        tick = (m_lc == int'(leak_period) - 1);
        m_lc = tick ? 0 : (m_lc + 1) % 256;
      end
      for (int c = 0; c < 4; c++) begin
        m_spike[c] = 1'b0;
        if (m_refr[c] != 0) begin
          m_refr[c]--;
          if (s_valid && s_ch == c && m_dc < 255) m_dc++;
        end else begin
          m = m_mem[c];
          if (tick) m = (m > leak_amt) ? m - leak_amt : 0;
          if (s_valid && s_ch == c) m = (m + s_mag > 4095) ? 4095 : m + s_mag;
          if (threshold != 0 && m >= threshold) begin
            m_spike[c] = 1'b1;
            m_mem[c]   = 0;
            m_refr[c]  = (refractory == 0) ? 1 : refractory;
            m_sc       = (m_sc + 1) % 65536;
          end else begin
            m_mem[c] = m;
          end
        end
      end
    end
    e.spike = m_spike;
    e.mem   = 12'(m_mem[mem_sel]);
    e.sc    = 16'(m_sc);
    e.dc    = 8'(m_dc);
    e.rdy   = enable;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic send(int ch, int mag);
    s_valid = 1'b1;
    s_ch    = 2'(ch);
    s_mag   = 8'(mag);
    cycle();
    s_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic config_cycle(int thr, int amt, int per, int refr);
    enable      = 1'b0;
    threshold   = 12'(thr);
    leak_amt    = 8'(amt);
    leak_period = 8'(per);
    refractory  = 4'(refr);
    cycle();
    enable = 1'b1;
  endtask

  task automatic peek_mem(int sel, int exp, string name);
    mem_sel = 2'(sel);
    #1;
    check(name, 32'(mem_out), 32'(exp));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sb_spike", 32'(spike_o), 32'(e.spike));
        check("sb_mem", 32'(mem_out), 32'(e.mem));
        check("sb_spike_count", 32'(spike_count), 32'(e.sc));
        check("sb_drop_count", 32'(drop_count), 32'(e.dc));
        check("sb_ready", 32'(s_ready), 32'(e.rdy));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst_n = 1'b0; enable = 1'b0; threshold = 0; leak_amt = 0; leak_period = 0;
    refractory = 0; s_valid = 0; s_ch = 0; s_mag = 0; mem_sel = 0;
    @(negedge clk);
    idle(2);
    check("reset_spike", 32'(spike_o), 32'd0);
    check("reset_count", 32'(spike_count), 32'd0);
    rst_n = 1'b1;

    // T1/T2: fire, then refractory drops, then fire again
    config_cycle(100, 0, 0, 2);
    send(0, 60);
    send(0, 60);
    check("t1_spike", 32'(spike_o), 32'h1);
    check("t1_count", 32'(spike_count), 32'd1);
    peek_mem(0, 0, "t1_mem0");
    send(0, 200);
    check("t2_spike_low", 32'(spike_o), 32'h0);
    send(0, 200);
    check("t2_drops", 32'(drop_count), 32'd2);
    send(0, 200);
    check("t2_refire", 32'(spike_o), 32'h1);
    idle(3);

    // T3: leak walks mem1 down to zero
    config_cycle(0, 20, 4, 0);
    mem_sel = 1;
    send(1, 50);
    idle(4);
    peek_mem(1, 30, "t3_first_tick");
    idle(12);
    peek_mem(1, 0, "t3_floor");
    leak_period = 8;
    send(1, 200);
    idle(5);
    leak_period = 3;
    idle(262);

    // T4: saturation, then threshold at the ceiling with a zero-magnitude sample
    config_cycle(0, 0, 0, 1);
    mem_sel = 2;
    for (int i = 0; i < 20; i++) send(2, 255);
    peek_mem(2, 4095, "t4_clamp");
    threshold = 12'd4095;
    send(2, 0);
    check("t4_fire", 32'(spike_o), 32'h4);

    // T5: leak floors before the add
    config_cycle(0, 10, 1, 0);
    mem_sel = 3;
    send(3, 5);
    send(3, 7);
    peek_mem(3, 7, "t5_leak_then_add");

    // T6: enable drop mid-refractory, then reset
    config_cycle(400, 0, 0, 5);
    send(0, 255);
    send(0, 255);
    send(1, 150);
    send(1, 150);
    peek_mem(1, 300, "t6_mem1");
    enable = 1'b0;
    #1;
    check("t6_ready_low", 32'(s_ready), 32'd0);
    cycle();
    enable = 1'b1;
    peek_mem(1, 0, "t6_mem1_flushed");
    check("t6_count_held", 32'(spike_count), 32'(m_sc));
    send(0, 255);
    check("t6_no_drop", 32'(drop_count), 32'(m_dc));
    rst_n = 1'b0;
    cycle();
    check("t6_reset_sc", 32'(spike_count), 32'd0);
    check("t6_reset_dc", 32'(drop_count), 32'd0);
    rst_n = 1'b1;

    // Random traffic; config only moves while disabled
    config_cycle(300, 5, 6, 3);
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 999) >= 3);
      if (enable && $urandom_range(0, 99) < 3) begin
        enable      = 1'b0;
        threshold   = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 700));
        leak_amt    = 8'($urandom_range(0, 30));
        leak_period = 8'($urandom_range(0, 8));
        refractory  = 4'($urandom_range(0, 5));
      end else if (!enable && $urandom_range(0, 1) == 1) begin
        enable = 1'b1;
      end
      s_valid = ($urandom_range(0, 9) < 7);
      s_ch    = 2'($urandom_range(0, 3));
      s_mag   = 8'($urandom_range(0, 255));
      mem_sel = 2'($urandom_range(0, 3));
      cycle();
    end
    s_valid = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
